video_tx_timing: RTL and testbench
==================================

# video_tx_timing

Video output interface for the 48-bit dual-pixel video bus. Generates VS/HS/DE raster timing from programmable parameters, pulls pixel beats from an upstream source through a ready/valid handshake, and maps them onto the connector lane order consumed by the video input side. Sits at the end of the display path, driving the board video connector.

## Interface
- H_ACTIVE, 960: active beats per line; one beat is two pixels for type 00.
- H_FP, 44: horizontal front porch, in beats.
- H_SYNC, 22: HS pulse width, in beats.
- H_BP, 74: horizontal back porch, in beats.
- V_ACTIVE, 1080: active lines per frame.
- V_FP, 4: vertical front porch, in lines.
- V_SYNC, 5: VS pulse width, in lines.
- V_BP, 36: vertical back porch, in lines.
- POL, 1'b1: sync polarity. 1'b1 gives idle-high with low pulses. 1'b0 gives idle-low with high pulses.
- RGB_MAP_TYP, 2'b00: lane map. 00 is dual pixel. 01 is single pixel. 10 and 11 behave as 00.
- clk  in  1  pixel-beat clock; all logic runs in this domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- pix_data  in  48  {R0,G0,B0,R1,G1,B1} for type 00; {24'b0,R,G,B} for type 01.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  block consumes a beat this cycle.
- VIDEO_VS  out  1  vertical sync.
- VIDEO_HS  out  1  horizontal sync.
- VIDEO_DE  out  1  data enable.
- VIDEO_DA  out  48  mapped pixel data.
- frame_start  out  1  one-cycle pulse marking the first active beat of each frame.
- underflow  out  1  one-cycle pulse marking an active beat with no data.

## Operation
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is formed the same way from the vertical parameters. Every parameter is ≥1. Counters are 12 bits wide; each total must be ≤4096.
- run register:
  - Reset value 0.
  - run <= en each cycle; rst forces it to 0.
- Counters:
  - While run=0, h_cnt and v_cnt are held at 0.
  - While run=1, h_cnt increments and wraps from H_TOTAL-1 to 0.
  - v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Line and frame order: active, front porch, sync, back porch.
- Internal raster signals:
  - de_i = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs_i is true for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_i is true for whole lines with V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
- pix_ready = run && de_i. This is combinational from registers.
- Transfer occurs when pix_valid && pix_ready. pix_valid while pix_ready=0 is ignored and nothing is consumed.
- Type 00 mapping, applied to VIDEO_DA:
  - [47:40]=G0, [39:32]=B0, [31:24]=R0.
  - [23:16]=G1, [15:8]=B1, [7:0]=R1.
- Type 01 mapping, applied to VIDEO_DA: [35:28]=R, [23:16]=G, [11:4]=B. All other bits are 0.
- Missing data: if pix_ready=1 and pix_valid=0, the output beat keeps VIDEO_DE=1, VIDEO_DA=0, and underflow pulses. Raster timing never stalls.
- en deasserted mid-frame: raster aborts and outputs go idle. Re-assertion restarts at h=0, v=0.

## Timing
- All outputs are registered, with one cycle of latency from the counter state.
  - VIDEO_DE <= run && de_i.
  - VIDEO_DA <= the mapped pix_data on a transfer, else 0.
  - VIDEO_HS <= (run && hs_i) ? ~POL : POL. VIDEO_VS is formed the same way from vs_i.
  - frame_start <= run && h_cnt==0 && v_cnt==0. It is coincident with the first VIDEO_DE beat of the frame.
  - underflow <= pix_ready && !pix_valid.
- Data launched on a transfer at cycle N appears on VIDEO_DA at N+1, with VIDEO_DE=1.
- en start-up: en sampled 1 at cycle N gives run=1 and pix_ready=1 at N+1, and first VIDEO_DE, frame_start at N+2.
- en shut-down: en sampled 0 at cycle N gives pix_ready=0 at N+1 and idle outputs at N+2.
- Reset and idle values, which also apply whenever run=0 for one cycle:
  - VIDEO_DE=0, VIDEO_DA=0.
  - VIDEO_HS=VIDEO_VS=POL.
  - pix_ready=0, frame_start=0, underflow=0.
- rst mid-frame: everything is idle on the next edge; no partial-line completion.
- VS edges coincide with HS-counter wrap, i.e. h_cnt==0 of the sync lines, delayed by one cycle at the pins.

## Test plan
Common bench parameters:
- Horizontal: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, giving H_TOTAL=8.
- Vertical: V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, giving V_TOTAL=6. One frame is 48 cycles.

Scenarios:
- Reset: rst=1 for 5 cycles with en=1 -> DE=0, DA=0, HS=VS=1, pix_ready=0, frame_start=0 and underflow=0 throughout.
- Raster, en=1 and pix_valid=1 constant:
  - DE is high for 4 of every 8 cycles on lines 0–2 and low on lines 3–5.
  - HS is low for 2 cycles, starting 1 cycle after DE falls.
  - VS is low for exactly 8 cycles, on line 4.
  - frame_start is spaced every 48 cycles and coincides with the first DE.
- Type 00 mapping: pix_data=48'h112233445566 -> VIDEO_DA=48'h223311556644 one cycle later, with DE=1.
- Type 01 mapping: pix_data=48'h000000A1B2C3 -> VIDEO_DA=48'h000A10B20C30.
- Underflow: pix_valid=0 for the 3rd active beat of line 1 -> that output beat has DE=1, DA=0 and underflow=1 for exactly 1 cycle; the next frame_start is still 48 cycles after the previous one.
- en abort: en=0 sampled while h=2 on line 1 -> pix_ready=0 next cycle, outputs idle the cycle after. Re-assert en -> frame_start 2 cycles later, with full raster from h=0, v=0.
- POL=0: same stimulus as the raster scenario -> HS/VS idle 0 and pulse 1 with identical placement; reset values HS=VS=0.

Source files
------------

// File: rtl/video_tx_timing.sv
// video_tx_timing: programmable VS/HS/DE raster generator that pulls pixel beats
// over ready/valid and maps them onto the connector lane order.
module video_tx_timing #(
    parameter int H_ACTIVE = 960,
    parameter int H_FP = 44,
    parameter int H_SYNC = 22,
    parameter int H_BP = 74,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP = 4,
    parameter int V_SYNC = 5,
    parameter int V_BP = 36,
    parameter logic POL = 1'b1,
    parameter logic [1:0] RGB_MAP_TYP = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [47:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        VIDEO_VS,
    output logic        VIDEO_HS,
    output logic        VIDEO_DE,
    output logic [47:0] VIDEO_DA,
    output logic        frame_start,
    output logic        underflow
);
    localparam logic [11:0] HA = 12'(H_ACTIVE);
    localparam logic [11:0] HS_B = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_E = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VA = 12'(V_ACTIVE);
    localparam logic [11:0] VS_B = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_E = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    logic run;
    logic [11:0] h_cnt, v_cnt;
    logic de_i, hs_i, vs_i, h_wrap;
    logic [47:0] mapped;
    always_comb begin
        de_i = h_cnt < HA && v_cnt < VA;
        hs_i = h_cnt >= HS_B && h_cnt < HS_E;
        vs_i = v_cnt >= VS_B && v_cnt < VS_E;
        h_wrap = h_cnt == H_LAST;
        pix_ready = run && de_i;
        // single pixel sits on bits [35:28]/[23:16]/[11:4]; everything else is dual pixel
        mapped = RGB_MAP_TYP == 2'b01
            ? {12'b0, pix_data[23:16], 4'b0, pix_data[15:8], 4'b0, pix_data[7:0], 4'b0}
            : {pix_data[39:32], pix_data[31:24], pix_data[47:40],
               pix_data[15:8], pix_data[7:0], pix_data[23:16]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
            VIDEO_DE <= 1'b0;
            VIDEO_DA <= '0;
            VIDEO_HS <= POL;
            VIDEO_VS <= POL;
            frame_start <= 1'b0;
            underflow <= 1'b0;
        end else begin
            run <= en;
            h_cnt <= (!run || h_wrap) ? 12'd0 : h_cnt + 12'd1;
            v_cnt <= !run ? 12'd0 : h_wrap ? (v_cnt == V_LAST ? 12'd0 : v_cnt + 12'd1) : v_cnt;
            VIDEO_DE <= pix_ready;
            VIDEO_DA <= (pix_ready && pix_valid) ? mapped : '0;
            VIDEO_HS <= (run && hs_i) ? ~POL : POL;
            VIDEO_VS <= (run && vs_i) ? ~POL : POL;
            frame_start <= run && h_cnt == 12'd0 && v_cnt == 12'd0;
            underflow <= pix_ready && !pix_valid;
        end
    end
endmodule

// File: tb/tb_video_tx_timing.sv
// tb_video_tx_timing: directed raster, mapping, underflow, abort and reset checks on a
// POL=1/dual-pixel instance and a POL=0/single-pixel instance sharing one stimulus.
module tb_video_tx_timing;
    logic clk, rst, en, pix_valid;
    logic [47:0] pix_data;
    logic rdy0, vs0, hs0, de0, fs0, uf0;
    logic rdy1, vs1, hs1, de1, fs1, uf1;
    logic [47:0] da0, da1;
    int checks = 0;
    int failures = 0;
    logic [47:0] din [2] = '{48'h112233445566, 48'h000000A1B2C3};
    logic [47:0] m0 [2] = '{48'h223311556644, 48'h000000B2C3A1};
    logic [47:0] m1 [2] = '{48'h000440550660, 48'h000A10B20C30};

    video_tx_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .POL(1'b1), .RGB_MAP_TYP(2'b00)) u0 (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(rdy0), .VIDEO_VS(vs0), .VIDEO_HS(hs0), .VIDEO_DE(de0), .VIDEO_DA(da0),
        .frame_start(fs0), .underflow(uf0));

    video_tx_timing #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .POL(1'b0), .RGB_MAP_TYP(2'b01)) u1 (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(rdy1), .VIDEO_VS(vs1), .VIDEO_HS(hs1), .VIDEO_DE(de1), .VIDEO_DA(da1),
        .frame_start(fs1), .underflow(uf1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic de_at(int p);
        return (p % 8) < 4 && ((p / 8) % 6) < 3;
    endfunction
    function automatic logic hs_at(int p);
        return (p % 8) == 5 || (p % 8) == 6;
    endfunction
    function automatic logic vs_at(int p);
        return ((p / 8) % 6) == 4;
    endfunction
    // second frame carries the single-pixel pattern and drops beat h=2 of line 1
    function automatic int sel(int p);
        return (p / 48) % 2;
    endfunction
    function automatic logic vld(int p);
        return !((p / 48) == 1 && (p % 48) == 10);
    endfunction

    task automatic idle_chk();
        chk("idle_de0", de0, 0);
        chk("idle_da0", da0, 0);
        chk("idle_hs0", hs0, 1);
        chk("idle_vs0", vs0, 1);
        chk("idle_fs0", fs0, 0);
        chk("idle_uf0", uf0, 0);
        chk("idle_rdy0", rdy0, 0);
        chk("idle_de1", de1, 0);
        chk("idle_da1", da1, 0);
        chk("idle_hs1", hs1, 0);
        chk("idle_vs1", vs1, 0);
        chk("idle_rdy1", rdy1, 0);
    endtask

    task automatic check_pos(input int k);
        logic de;
        de = de_at(k);
        chk($sformatf("de0[%0d]", k), de0, de);
        chk($sformatf("de1[%0d]", k), de1, de);
        chk($sformatf("da0[%0d]", k), da0, (de && vld(k)) ? m0[sel(k)] : 48'h0);
        chk($sformatf("da1[%0d]", k), da1, (de && vld(k)) ? m1[sel(k)] : 48'h0);
        chk($sformatf("hs0[%0d]", k), hs0, !hs_at(k));
        chk($sformatf("vs0[%0d]", k), vs0, !vs_at(k));
        chk($sformatf("hs1[%0d]", k), hs1, hs_at(k));
        chk($sformatf("vs1[%0d]", k), vs1, vs_at(k));
        chk($sformatf("fs0[%0d]", k), fs0, (k % 48) == 0);
        chk($sformatf("fs1[%0d]", k), fs1, (k % 48) == 0);
        chk($sformatf("uf0[%0d]", k), uf0, de && !vld(k));
    endtask

    // en must already be 1 so that the next edge starts the raster at h=0, v=0
    task automatic run(input int cnt, input int stop_k);
        pix_data = din[sel(0)];
        pix_valid = vld(0);
        @(posedge clk); #1;
        chk("rdy_start", rdy0, 1);
        for (int k = 0; k < cnt; k++) begin
            @(posedge clk); #1;
            check_pos(k);
            chk($sformatf("rdy0[%0d]", k + 1), rdy0, de_at(k + 1));
            chk($sformatf("rdy1[%0d]", k + 1), rdy1, de_at(k + 1));
            pix_data = din[sel(k + 1)];
            pix_valid = vld(k + 1);
            if (k == stop_k) en = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        pix_valid = 1'b1;
        pix_data = din[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle_chk();
        end
        rst = 1'b0;
        run(154, 153);
        @(posedge clk); #1;
        chk("abort_rdy0", rdy0, 0);
        chk("abort_de0_last", de0, 1);
        @(posedge clk); #1;
        idle_chk();
        en = 1'b1;
        run(49, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        idle_chk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
